// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction buffer between the dual-issue fetch stage and the two decoders.
//   Fetch pushes 64-bit packets that hold up to two instructions. Decode sees the
//   two oldest instructions, each tagged with its PC, and pops 0..2 per cycle.
//   A flush empties the queue.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      redirect; empties the queue on the next edge
//   in_valid   per-slot valid: [0] = in_inst[31:0] @ in_pc, [1] = in_inst[63:32] @ in_pc+4
//   in_pc      packet PC (8-byte aligned)
//   in_inst    instruction pair
//   in_ready   a full two-instruction packet can be accepted this cycle
//   out0_*     oldest instruction (valid/inst/pc); inst and pc are zero when not valid
//   out1_*     second-oldest instruction
//   out_take   number of instructions consumed by decode (3 is treated as 2)
//   count      current occupancy
module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [31:0]                in_pc,
    input  logic [63:0]                in_inst,
    output logic                       in_ready,
    output logic                       out0_valid,
    output logic [31:0]                out0_inst,
    output logic [31:0]                out0_pc,
    output logic                       out1_valid,
    output logic [31:0]                out1_inst,
    output logic [31:0]                out1_pc,
    input  logic [1:0]                 out_take,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] rd_ptr1, wr_ptr1;
    logic          push;
    logic [1:0]    push_n;
    logic [1:0]    take_req;
    logic [1:0]    eff_take;
    entry_t        head0, head1;

    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    // Space check uses only registered count so decode activity never reaches
    // in_ready combinationally. Gated by reset so fetch sees no space while held.
    assign in_ready = reset && !flush && (count <= CW'(DEPTH - 2));

    assign push   = in_ready && (|in_valid);
    assign push_n = push ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

    // Illegal take of 3 behaves as 2, then clip to what is actually present.
    assign take_req = (out_take == 2'd3) ? 2'd2 : out_take;
    assign eff_take = (CW'(take_req) > count) ? count[1:0] : take_req;

    // Storage is not reset; only the pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            unique case (in_valid)
                2'b01: mem[wr_ptr] <= '{pc: in_pc, inst: in_inst[31:0]};
                2'b10: mem[wr_ptr] <= '{pc: in_pc + 32'd4, inst: in_inst[63:32]};
                2'b11: begin
                    mem[wr_ptr]  <= '{pc: in_pc, inst: in_inst[31:0]};
                    mem[wr_ptr1] <= '{pc: in_pc + 32'd4, inst: in_inst[63:32]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(eff_take);
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + CW'(push_n) - CW'(eff_take);
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr1];

    assign out0_valid = (count >= CW'(1));
    assign out1_valid = (count >= CW'(2));
    assign out0_inst  = out0_valid ? head0.inst : 32'h0;
    assign out0_pc    = out0_valid ? head0.pc   : 32'h0;
    assign out1_inst  = out1_valid ? head1.inst : 32'h0;
    assign out1_pc    = out1_valid ? head1.pc   : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=8).
module tb_inst_fetch_queue;
    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc;
    logic [63:0] in_inst;
    logic        in_ready;
    logic        out0_valid;
    logic [31:0] out0_inst;
    logic [31:0] out0_pc;
    logic        out1_valid;
    logic [31:0] out1_inst;
    logic [31:0] out1_pc;
    logic [1:0]  out_take;
    logic [3:0]  count;

    int checks;
    int failures;

    inst_fetch_queue #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out0_valid(out0_valid), .out0_inst(out0_inst), .out0_pc(out0_pc),
        .out1_valid(out1_valid), .out1_inst(out1_inst), .out1_pc(out1_pc),
        .out_take(out_take), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction words are tagged with their packet PC so order is traceable.
    function automatic logic [31:0] lo(input logic [31:0] pc);
        return 32'h1000_0000 | pc;
    endfunction
    function automatic logic [31:0] hi(input logic [31:0] pc);
        return 32'h2000_0000 | pc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("count_bound", 64'(count <= 4'd8), 64'd1);
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] v);
        in_valid = v;
        in_pc    = pc;
        in_inst  = {hi(pc), lo(pc)};
        tick();
        in_valid = 2'b00;
        #1;
    endtask

    task automatic take(input logic [1:0] n);
        out_take = n;
        tick();
        out_take = 2'd0;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 2'b00; in_pc = '0; in_inst = '0; out_take = 2'd0;
        #1 reset = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out0_valid", 64'(out0_valid), 64'd0);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 1: reset mid-operation at count=5
        push(32'h00, 2'b11);
        push(32'h08, 2'b11);
        push(32'h10, 2'b01);
        chk("t1_count5", 64'(count), 64'd5);
        reset = 1'b0;
        #1;
        chk("t1_async_count", 64'(count), 64'd0);
        chk("t1_async_out0_valid", 64'(out0_valid), 64'd0);
        chk("t1_async_out1_valid", 64'(out1_valid), 64'd0);
        chk("t1_async_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t1_release_in_ready", 64'(in_ready), 64'd1);

        // 2: fill
        push(32'h00, 2'b11);
        push(32'h08, 2'b11);
        push(32'h10, 2'b11);
        chk("t2_count6", 64'(count), 64'd6);
        chk("t2_ready6", 64'(in_ready), 64'd1);
        chk("t2_out0_pc", 64'(out0_pc), 64'h0);
        chk("t2_out0_inst", 64'(out0_inst), 64'(lo(32'h0)));
        chk("t2_out1_pc", 64'(out1_pc), 64'h4);
        chk("t2_out1_inst", 64'(out1_inst), 64'(hi(32'h0)));
        push(32'h18, 2'b11);
        chk("t2_count8", 64'(count), 64'd8);
        chk("t2_ready8", 64'(in_ready), 64'd0);
        push(32'h20, 2'b11);
        chk("t2_blocked_count", 64'(count), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc0", 64'(out0_pc), 64'(32'h8 * i));
            chk("t2_drain_pc1", 64'(out1_pc), 64'(32'h8 * i + 4));
            take(2'd2);
        end
        chk("t2_empty_count", 64'(count), 64'd0);
        chk("t2_empty_valid", 64'(out0_valid), 64'd0);
        chk("t2_empty_pc", 64'(out0_pc), 64'd0);

        // 3: partial packets
        push(32'h100, 2'b10);
        push(32'h108, 2'b01);
        chk("t3_out0_pc", 64'(out0_pc), 64'h104);
        chk("t3_out0_inst", 64'(out0_inst), 64'(hi(32'h100)));
        chk("t3_out1_pc", 64'(out1_pc), 64'h108);
        chk("t3_out1_inst", 64'(out1_inst), 64'(lo(32'h108)));
        chk("t3_count", 64'(count), 64'd2);
        take(2'd2);
        chk("t3_drained", 64'(count), 64'd0);

        // 4: concurrent push and take across wrap
        push(32'h00, 2'b11);
        for (int i = 0; i < 10; i++) begin
            in_valid = 2'b11;
            in_pc    = 32'h8 * (i + 1);
            in_inst  = {hi(in_pc), lo(in_pc)};
            out_take = 2'd2;
            #1;
            chk("t4_out0_pc", 64'(out0_pc), 64'(32'h8 * i));
            chk("t4_out1_inst", 64'(out1_inst), 64'(hi(32'h8 * i)));
            chk("t4_count", 64'(count), 64'd2);
            tick();
        end
        in_valid = 2'b00; out_take = 2'd0;
        #1;
        chk("t4_final_pc", 64'(out0_pc), 64'h50);
        chk("t4_final_count", 64'(count), 64'd2);

        // 5: underflow and clipping
        take(2'd1);
        chk("t5_count1", 64'(count), 64'd1);
        chk("t5_out0_pc", 64'(out0_pc), 64'h54);
        take(2'd2);
        chk("t5_clip_count", 64'(count), 64'd0);
        take(2'd1);
        chk("t5_empty_take", 64'(count), 64'd0);
        push(32'h300, 2'b01);
        chk("t5_rdptr_pc", 64'(out0_pc), 64'h300);
        chk("t5_rdptr_inst", 64'(out0_inst), 64'(lo(32'h300)));
        push(32'h308, 2'b11);
        chk("t5_count3", 64'(count), 64'd3);
        take(2'd3);
        chk("t5_take3_count", 64'(count), 64'd1);
        chk("t5_take3_pc", 64'(out0_pc), 64'h30C);
        take(2'd1);

        // 6: flush with concurrent push and pop
        push(32'h400, 2'b11);
        push(32'h408, 2'b11);
        chk("t6_count4", 64'(count), 64'd4);
        flush = 1'b1; in_valid = 2'b11; in_pc = 32'h410; in_inst = {hi(32'h410), lo(32'h410)};
        out_take = 2'd2;
        #1;
        chk("t6_flush_ready", 64'(in_ready), 64'd0);
        chk("t6_flush_out0_pc", 64'(out0_pc), 64'h400);
        tick();
        flush = 1'b0; in_valid = 2'b00; out_take = 2'd0;
        #1;
        chk("t6_post_count", 64'(count), 64'd0);
        chk("t6_post_valid", 64'(out0_valid), 64'd0);
        chk("t6_post_ready", 64'(in_ready), 64'd1);
        push(32'h200, 2'b11);
        chk("t6_new_pc0", 64'(out0_pc), 64'h200);
        chk("t6_new_pc1", 64'(out1_pc), 64'h204);
        chk("t6_new_count", 64'(count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
